// File: rtl/meter_controller.sv
// Parking meter sequencing controller: coin/start synchronization, saturating
// credit in seconds, 1 Hz countdown gating and registered BCD display outputs.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | no credit, waiting for the first coin
// S_LOADED  | credit > 0, countdown paused until start is high
// S_RUN     | counting down one second per prescaler wrap
// S_EXPIRED | credit used up, blink strobe toggles each second
module meter_controller #(
   parameter int TICK_DIV = 50_000_000,
   parameter int COIN0_S  = 5,
   parameter int COIN1_S  = 10,
   parameter int COIN2_S  = 20,
   parameter int MAX_S    = 99
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] sw_coin,
   input  logic       sw_start,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       running,
   output logic       expired,
   output logic       blink
);

   typedef enum logic [1:0] {S_IDLE, S_LOADED, S_RUN, S_EXPIRED} state_t;

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [7:0] C0   = 8'(COIN0_S);
   localparam logic [7:0] C1   = 8'(COIN1_S);
   localparam logic [7:0] C2   = 8'(COIN2_S);
   localparam logic [7:0] MAX8 = 8'(MAX_S);

   logic [2:0]    coin_s1_q, coin_s1_d, coin_s2_q, coin_s2_d, coin_prev_q, coin_prev_d;
   logic          start_s1_q, start_s1_d, start_s2_q, start_s2_d;
   state_t        state_q, state_d;
   logic [6:0]    credit_q, credit_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          blink_q, blink_d;
   logic          running_q, running_d, expired_q, expired_d;
   logic [3:0]    tens_q, tens_d, ones_q, ones_d;

   logic [2:0] coin_edge;
   logic [7:0] add, sum, sat, sat_m1;
   logic       tick;

   // Next-state logic: synchronizers, saturating credit, FSM, prescaler, outputs.
   always_comb begin
      coin_s1_d   = sw_coin;
      coin_s2_d   = coin_s1_q;
      coin_prev_d = coin_s2_q;
      start_s1_d  = sw_start;
      start_s2_d  = start_s1_q;

      coin_edge = coin_s2_q & ~coin_prev_q;
      add    = (coin_edge[0] ? C0 : 8'd0) + (coin_edge[1] ? C1 : 8'd0)
             + (coin_edge[2] ? C2 : 8'd0);
      sum    = {1'b0, credit_q} + add;
      sat    = (sum > MAX8) ? MAX8 : sum;
      sat_m1 = sat - 8'd1;
      tick   = ((state_q == S_RUN) || (state_q == S_EXPIRED)) && (presc_q == PRESC_LAST);

      state_d  = state_q;
      credit_d = sat[6:0];
      blink_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (|coin_edge) state_d = S_LOADED;
         end
         S_LOADED: begin
            if (start_s2_q) state_d = S_RUN;
         end
         S_RUN: begin
            if (!start_s2_q) begin
               // Pause: tick on this cycle is dropped, credit holds.
               state_d = S_LOADED;
            end else begin
               if (tick && (sat != 8'd0)) credit_d = sat_m1[6:0];
               if (tick && (credit_d == 7'd0)) state_d = S_EXPIRED;
            end
         end
         S_EXPIRED: begin
            blink_d = tick ? ~blink_q : blink_q;
            if (|coin_edge) begin
               state_d = start_s2_q ? S_RUN : S_LOADED;
               blink_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_LOADED)) begin
         presc_d = '0;
      end else begin
         presc_d = tick ? '0 : presc_q + 1'b1;
      end

      running_d = (state_d == S_RUN);
      expired_d = (state_d == S_EXPIRED);
      tens_d    = 4'(credit_d / 7'd10);
      ones_d    = 4'(credit_d % 7'd10);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         coin_s1_q   <= '0;
         coin_s2_q   <= '0;
         coin_prev_q <= '0;
         start_s1_q  <= 1'b0;
         start_s2_q  <= 1'b0;
         state_q     <= S_IDLE;
         credit_q    <= '0;
         presc_q     <= '0;
         blink_q     <= 1'b0;
         running_q   <= 1'b0;
         expired_q   <= 1'b0;
         tens_q      <= '0;
         ones_q      <= '0;
      end else begin
         coin_s1_q   <= coin_s1_d;
         coin_s2_q   <= coin_s2_d;
         coin_prev_q <= coin_prev_d;
         start_s1_q  <= start_s1_d;
         start_s2_q  <= start_s2_d;
         state_q     <= state_d;
         credit_q    <= credit_d;
         presc_q     <= presc_d;
         blink_q     <= blink_d;
         running_q   <= running_d;
         expired_q   <= expired_d;
         tens_q      <= tens_d;
         ones_q      <= ones_d;
      end
   end

   assign tens    = tens_q;
   assign ones    = ones_q;
   assign running = running_q;
   assign expired = expired_q;
   assign blink   = blink_q;

endmodule

// File: tb/tb_meter_controller.sv
// Bench for meter_controller: directed vector table, hand-timed corner cases,
// and random stimulus compared every cycle against a behavioural model.
module tb_meter_controller;

   localparam int TD = 10;
   localparam int M_IDLE = 0, M_LOADED = 1, M_RUN = 2, M_EXPIRED = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] sw_coin = 3'b000;
   logic       sw_start = 1'b0;
   logic [3:0] tens, ones;
   logic       running, expired, blink;

   meter_controller #(.TICK_DIV(TD), .COIN0_S(5), .COIN1_S(10), .COIN2_S(20), .MAX_S(99)) dut (
      .clk(clk), .reset(reset), .sw_coin(sw_coin), .sw_start(sw_start),
      .tens(tens), .ones(ones), .running(running), .expired(expired), .blink(blink)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: seconds of credit, mode, cycles spent in current mode.
   int m_credit = 0, m_mode = M_IDLE, m_count = 0;
   bit m_blink = 1'b0;
   bit [2:0] ch [3];
   bit sh [3];
   int m_add, m_sat, m_old;
   bit m_tick, m_st;
   bit [2:0] m_edges;

   always @(posedge clk) begin
      if (reset) begin
         m_credit = 0; m_mode = M_IDLE; m_count = 0; m_blink = 1'b0;
         for (int i = 0; i < 3; i++) begin ch[i] = 3'b000; sh[i] = 1'b0; end
      end else begin
         m_edges = ch[1] & ~ch[2];
         m_st    = sh[1];
         m_add   = (m_edges[0] ? 5 : 0) + (m_edges[1] ? 10 : 0) + (m_edges[2] ? 20 : 0);
         m_sat   = (m_credit + m_add > 99) ? 99 : m_credit + m_add;
         m_tick  = (m_mode == M_RUN || m_mode == M_EXPIRED) && (m_count % TD == TD - 1);
         m_old   = m_mode;
         case (m_mode)
            M_IDLE: begin m_credit = m_sat; if (m_add > 0) m_mode = M_LOADED; end
            M_LOADED: begin m_credit = m_sat; if (m_st) m_mode = M_RUN; end
            M_RUN: begin
               if (!m_st) begin m_credit = m_sat; m_mode = M_LOADED; end
               else begin
                  m_credit = (m_tick && m_sat > 0) ? m_sat - 1 : m_sat;
                  if (m_tick && m_credit == 0) m_mode = M_EXPIRED;
               end
            end
            default: begin
               if (m_add > 0) begin
                  m_credit = m_sat; m_mode = m_st ? M_RUN : M_LOADED; m_blink = 1'b0;
               end else if (m_tick) m_blink = !m_blink;
            end
         endcase
         if (m_mode != m_old) m_count = 0; else m_count++;
         ch[2] = ch[1]; ch[1] = ch[0]; ch[0] = sw_coin;
         sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = sw_start;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en && !reset) begin
         chk("model_tens", tens, m_credit / 10);
         chk("model_ones", ones, m_credit % 10);
         chk("model_running", running, m_mode == M_RUN);
         chk("model_expired", expired, m_mode == M_EXPIRED);
         chk("model_blink", blink, m_blink);
      end
   end

   typedef struct {
      logic [2:0] coin;
      logic       start;
      int         n;
      int         e_tens, e_ones;
      bit         e_run, e_exp, e_blink;
   } vec_t;
   vec_t vt[$];

   task automatic addv(input logic [2:0] c, input logic s, input int n, input int t, input int o,
                       input bit r, input bit e, input bit b);
      vec_t v;
      v.coin = c; v.start = s; v.n = n; v.e_tens = t; v.e_ones = o;
      v.e_run = r; v.e_exp = e; v.e_blink = b;
      vt.push_back(v);
   endtask

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic chk_all(input string name, input int t, input int o, input bit r, input bit e, input bit b);
      chk({name, "_tens"}, tens, t);
      chk({name, "_ones"}, ones, o);
      chk({name, "_running"}, running, r);
      chk({name, "_expired"}, expired, e);
      chk({name, "_blink"}, blink, b);
   endtask

   int sat_vals[6] = '{29, 49, 69, 89, 99, 99};

   initial begin
      // Credit, countdown, expiry, blink, coin from EXPIRED, pause, saturation.
      addv(3'b000, 0, 3, 0, 0, 0, 0, 0);
      addv(3'b001, 0, 5, 0, 5, 0, 0, 0);
      addv(3'b000, 0, 5, 0, 5, 0, 0, 0);
      addv(3'b010, 0, 5, 1, 5, 0, 0, 0);
      addv(3'b000, 0, 5, 1, 5, 0, 0, 0);
      addv(3'b000, 1, 3, 1, 5, 1, 0, 0);
      addv(3'b000, 1, 10, 1, 4, 1, 0, 0);
      addv(3'b000, 1, 139, 0, 1, 1, 0, 0);
      addv(3'b000, 1, 1, 0, 0, 0, 1, 0);
      addv(3'b000, 1, 9, 0, 0, 0, 1, 0);
      addv(3'b000, 1, 1, 0, 0, 0, 1, 1);
      addv(3'b000, 1, 10, 0, 0, 0, 1, 0);
      addv(3'b010, 1, 3, 1, 0, 1, 0, 0);
      addv(3'b000, 1, 5, 1, 0, 1, 0, 0);
      addv(3'b000, 0, 3, 1, 0, 0, 0, 0);
      addv(3'b000, 0, 100, 1, 0, 0, 0, 0);
      addv(3'b000, 1, 3, 1, 0, 1, 0, 0);
      addv(3'b000, 1, 9, 1, 0, 1, 0, 0);
      addv(3'b000, 1, 1, 0, 9, 1, 0, 0);
      addv(3'b000, 0, 3, 0, 9, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         addv(3'b100, 0, 3, sat_vals[i] / 10, sat_vals[i] % 10, 0, 0, 0);
         addv(3'b000, 0, 3, sat_vals[i] / 10, sat_vals[i] % 10, 0, 0, 0);
      end
      addv(3'b111, 0, 3, 9, 9, 0, 0, 0);
      addv(3'b000, 0, 3, 9, 9, 0, 0, 0);

      #1;
      chk_all("reset", 0, 0, 0, 0, 0);
      cyc(2);
      reset = 1'b0;
      chk_en = 1'b1;

      for (int i = 0; i < vt.size(); i++) begin
         sw_coin = vt[i].coin;
         sw_start = vt[i].start;
         cyc(vt[i].n);
         chk_all($sformatf("vec%0d", i), vt[i].e_tens, vt[i].e_ones, vt[i].e_run, vt[i].e_exp, vt[i].e_blink);
      end

      // Tick and coin edge land on the same cycle at credit 1.
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      sw_coin = 3'b001; cyc(3);
      sw_coin = 3'b000; cyc(3);
      chk_all("coll_loaded", 0, 5, 0, 0, 0);
      sw_start = 1'b1;
      cyc(50);
      chk_all("coll_pre", 0, 1, 1, 0, 0);
      sw_coin = 3'b001; cyc(3);
      chk_all("coll_hit", 0, 5, 1, 0, 0);
      sw_coin = 3'b000; cyc(4);
      chk_all("coll_after", 0, 5, 1, 0, 0);

      // Asynchronous reset in the middle of RUN.
      reset = 1'b1;
      #1;
      chk_all("async_reset", 0, 0, 0, 0, 0);
      cyc(1);
      reset = 1'b0;

      // Reach EXPIRED with start held, then a coin goes straight to RUN.
      sw_coin = 3'b001; cyc(3);
      sw_coin = 3'b000;
      for (int i = 0; i < 100 && !expired; i++) cyc(1);
      chk("reach_expired", expired, 1);
      sw_coin = 3'b010; cyc(3);
      chk_all("exp_to_run", 1, 0, 1, 0, 0);
      sw_coin = 3'b000; cyc(3);

      // Random stimulus, checked every cycle by the model.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            reset = 1'b1; cyc(1); reset = 1'b0;
         end
         for (int b = 0; b < 3; b++)
            if ($urandom_range(0, 11) == 0) sw_coin[b] = ~sw_coin[b];
         if ($urandom_range(0, 59) == 0) sw_start = ~sw_start;
         cyc(1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
